// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the router packet source: header layout, FSM states
// and small byte helpers.
package router_pkg;

    localparam int unsigned LEN_W    = 6;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_LEN_LSB  = ADDR_W;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_ERRCHK  = 3'd4
    } tx_state_t;

    // Header byte: length in the upper bits, destination in the lower bits.
    function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                               input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

    function automatic logic [7:0] xor8(input logic [7:0] a, input logic [7:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Load bus and router link of the packet source. The packet source is the
// master; the loader/router side is the slave.
interface router_pkt_tx_if;

    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       router_busy;
    logic       router_err;

    modport master (
        input  ld_valid, ld_data, router_busy, router_err,
        output ld_ready, pkt_valid, pkt_data
    );

    modport slave (
        output ld_valid, ld_data, router_busy, router_err,
        input  ld_ready, pkt_valid, pkt_data
    );

endinterface

// File: rtl/router_pkt_tx_buf.sv
// DEPTH x 8 circular payload buffer. Exposes the head byte and the byte after
// it so the packet FSM can register the next output byte in the same cycle
// it pops the current one.
module router_tx_buf #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [7:0]                 wr_data_i,
    input  logic                       rd_en_i,
    output logic [7:0]                 head_o,
    output logic [7:0]                 next_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] count_q;

    assign rd_nxt  = rd_ptr_q + AW'(1);
    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_nxt];
    assign count_o = count_q;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_nxt;
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers payload bytes, then sends
// header / payload / parity under router busy back-pressure and reports
// whether the router flagged an error afterwards.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ERR_WAIT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    router_pkt_tx_if.master        bus,
    input  logic                   start,
    input  logic [1:0]             dest_addr,
    input  logic [5:0]             pay_len,
    input  logic                   inj_perr,
    output logic                   tx_active,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done,
    output logic                   err_seen,
    output logic                   cmd_reject
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inj_q, inj_d;
    logic [7:0]        parity_q, parity_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [7:0]        pkt_data_q, pkt_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rej_q, rej_d;

    logic              idle;
    logic              ld_fire;
    logic              rd_en;
    logic              start_bad;
    logic [7:0]        hdr;
    logic [7:0]        head_byte;
    logic [7:0]        next_byte;
    logic [CW-1:0]     count_w;

    assign idle      = (state_q == S_IDLE);
    assign bus.ld_ready = idle && (count_w < CW'(DEPTH));
    assign ld_fire   = bus.ld_valid && bus.ld_ready;
    assign rd_en     = (state_q == S_PAYLOAD) && !bus.router_busy;
    assign hdr       = make_header(pay_len, dest_addr);
    assign start_bad = (pay_len == '0) ||
                       (8'(pay_len) > 8'(count_w)) ||
                       (dest_addr == ADDR_INVALID);

    router_tx_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (ld_fire),
        .wr_data_i (bus.ld_data),
        .rd_en_i   (rd_en),
        .head_o    (head_byte),
        .next_o    (next_byte),
        .count_o   (count_w)
    );

    // Next-state and next-output decode; output bytes are prepared one cycle
    // ahead so pkt_data/pkt_valid come straight from flops.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        inj_d       = inj_q;
        parity_d    = parity_q;
        wait_d      = wait_q;
        pkt_valid_d = pkt_valid_q;
        pkt_data_d  = pkt_data_q;
        done_d      = 1'b0;
        rej_d       = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        rej_d = 1'b1;
                    end else begin
                        state_d     = S_HEADER;
                        rem_d       = pay_len;
                        inj_d       = inj_perr;
                        parity_d    = hdr;
                        err_d       = 1'b0;
                        pkt_valid_d = 1'b1;
                        pkt_data_d  = hdr;
                    end
                end
            end
            S_HEADER: begin
                if (!bus.router_busy) begin
                    state_d    = S_PAYLOAD;
                    pkt_data_d = head_byte;
                end
            end
            S_PAYLOAD: begin
                if (!bus.router_busy) begin
                    parity_d = xor8(parity_q, pkt_data_q);
                    rem_d    = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d     = S_PARITY;
                        pkt_valid_d = 1'b0;
                        pkt_data_d  = xor8(parity_d, {7'b0, inj_q});
                    end else begin
                        pkt_data_d  = next_byte;
                    end
                end
            end
            S_PARITY: begin
                if (!bus.router_busy) begin
                    state_d    = S_ERRCHK;
                    pkt_data_d = '0;
                    wait_d     = WW'(ERR_WAIT - 1);
                end
            end
            S_ERRCHK: begin
                err_d = err_q | bus.router_err;
                if (wait_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    wait_d  = wait_q - WW'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                pkt_valid_d = 1'b0;
                pkt_data_d  = '0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any packet immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            inj_q       <= 1'b0;
            parity_q    <= '0;
            wait_q      <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            inj_q       <= inj_d;
            parity_q    <= parity_d;
            wait_q      <= wait_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rej_q       <= rej_d;
        end
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_data  = pkt_data_q;
    assign tx_active     = !idle;
    assign count         = count_w;
    assign done          = done_q;
    assign err_seen      = err_q;
    assign cmd_reject    = rej_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised bench for router_pkt_tx against a queue-based packet model.
module tb_router_pkt_tx;

    localparam int DEPTH = 16;
    localparam int EW    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       inj_perr;
    logic       tx_active;
    logic [4:0] count;
    logic       done;
    logic       err_seen;
    logic       cmd_reject;

    router_pkt_tx_if bus ();

    router_pkt_tx #(.DEPTH(DEPTH), .ERR_WAIT(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .start      (start),
        .dest_addr  (dest_addr),
        .pay_len    (pay_len),
        .inj_perr   (inj_perr),
        .tx_active  (tx_active),
        .count      (count),
        .done       (done),
        .err_seen   (err_seen),
        .cmd_reject (cmd_reject)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start           = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.router_busy = 1'b0;
        bus.router_err  = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        @(negedge clk);
        check_val("count_pre_load", count, model_q.size());
        check_val("ld_ready", bus.ld_ready, model_q.size() < DEPTH);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        if (model_q.size() < DEPTH) model_q.push_back(b);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        check_val("count_post_load", count, model_q.size());
    endtask

    // err_k: index of the post-parity cycle on which router_err is raised (-1: none)
    task automatic send_pkt(input int len, input int addr, input bit perr,
                            input int busy_pct, input int hold_idx, input int hold_n,
                            input int err_k);
        logic [7:0] exp[$];
        logic [7:0] par;
        logic [7:0] b;
        logic [5:0] l6;
        logic [1:0] a2;
        bit         accept;
        bit         busy;
        bit         exp_err;
        int         size0, idx, cycles, holds;

        size0  = model_q.size();
        accept = (len != 0) && (len <= size0) && (addr != 3);
        l6     = len[5:0];
        a2     = addr[1:0];
        @(negedge clk);
        start = 1'b1; pay_len = l6; dest_addr = a2; inj_perr = perr;
        @(negedge clk);
        start = 1'b0;
        if (!accept) begin
            check_val("cmd_reject", cmd_reject, 1);
            check_val("rej_pkt_valid", bus.pkt_valid, 0);
            check_val("rej_tx_active", tx_active, 0);
            check_val("rej_count", count, size0);
            @(negedge clk);
            check_val("cmd_reject_pulse", cmd_reject, 0);
            return;
        end
        check_val("acc_no_reject", cmd_reject, 0);

        par = {l6, a2};
        exp.push_back(par);
        for (int i = 0; i < len; i++) begin
            b = model_q.pop_front();
            exp.push_back(b);
            par = par ^ b;
        end
        exp.push_back(par ^ {7'b0, perr});

        idx = 0; cycles = 0; holds = 0;
        while (idx < len + 2 && cycles < 500) begin
            check_val("pkt_data", bus.pkt_data, exp[idx]);
            check_val("pkt_valid", bus.pkt_valid, idx <= len);
            check_val("tx_active", tx_active, 1);
            check_val("count_tx", count, size0 - ((idx == 0) ? 0 : idx - 1));
            check_val("no_reject_busy", cmd_reject, 0);
            check_val("no_done_tx", done, 0);
            if (idx == hold_idx && holds < hold_n) begin
                busy = 1'b1;
                holds++;
            end else begin
                busy = ($urandom_range(99) < busy_pct);
            end
            bus.router_busy = busy;
            bus.router_err  = 1'($urandom_range(1));
            start           = 1'($urandom_range(1));
            pay_len         = 6'($urandom_range(63));
            bus.ld_valid    = 1'($urandom_range(1));
            bus.ld_data     = 8'($urandom_range(255));
            if (!busy) idx++;
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 500) check_val("pkt_timeout", 0, 1);
        if (busy_pct == 0) check_val("pkt_cycles", cycles, len + 2 + hold_n);

        exp_err = 1'b0;
        for (int k = 0; k < EW; k++) begin
            check_val("errchk_valid", bus.pkt_valid, 0);
            check_val("errchk_data", bus.pkt_data, 0);
            check_val("errchk_active", tx_active, 1);
            check_val("errchk_done", done, 0);
            bus.router_busy = 1'($urandom_range(1));
            bus.router_err  = (k == err_k);
            exp_err         = exp_err | (k == err_k);
            start           = 1'($urandom_range(1));
            bus.ld_valid    = 1'($urandom_range(1));
            @(negedge clk);
        end
        check_val("done", done, 1);
        check_val("err_seen", err_seen, exp_err);
        check_val("idle_after", tx_active, 0);
        check_val("count_after", count, model_q.size());
        check_val("ld_ready_after", bus.ld_ready, model_q.size() < DEPTH);
        idle_inputs();
        @(negedge clk);
        check_val("done_pulse", done, 0);
        check_val("err_seen_hold", err_seen, exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.ld_data = '0; pay_len = '0; dest_addr = '0; inj_perr = 1'b0;
        #12;
        check_val("rst_pkt_valid", bus.pkt_valid, 0);
        check_val("rst_pkt_data", bus.pkt_data, 0);
        check_val("rst_ld_ready", bus.ld_ready, 1);
        check_val("rst_tx_active", tx_active, 0);
        check_val("rst_count", count, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err_seen", err_seen, 0);
        check_val("rst_cmd_reject", cmd_reject, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: plain packet, 2: busy hold on 0x55, 3: injected parity + router err
        for (int t = 0; t < 3; t++) begin
            load_byte(8'hAA); load_byte(8'h55); load_byte(8'hCC); load_byte(8'h33);
            case (t)
                0:       send_pkt(4, 1, 1'b0, 0, -1, 0, -1);
                1:       send_pkt(4, 1, 1'b0, 0, 2, 2, -1);
                default: send_pkt(4, 1, 1'b1, 0, -1, 0, 1);
            endcase
        end

        // 4: rejected commands, then drain
        load_byte(8'h01); load_byte(8'h02); load_byte(8'h03); load_byte(8'h04);
        send_pkt(0, 1, 1'b0, 0, -1, 0, -1);
        send_pkt(5, 1, 1'b0, 0, -1, 0, -1);
        send_pkt(4, 3, 1'b0, 0, -1, 0, -1);
        send_pkt(4, 0, 1'b0, 0, -1, 0, -1);

        // 5: fill, overfill attempt, two packets across pointer wrap
        for (int i = 1; i <= DEPTH + 1; i++) load_byte(8'(i));
        send_pkt(10, 2, 1'b0, 0, -1, 0, -1);
        send_pkt(6, 1, 1'b0, 20, -1, 0, -1);

        // 6: asynchronous reset in the middle of the payload
        load_byte(8'h10); load_byte(8'h20); load_byte(8'h30); load_byte(8'h40);
        @(negedge clk);
        start = 1'b1; pay_len = 6'd4; dest_addr = 2'd0; inj_perr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("mid_pkt_valid", bus.pkt_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_pkt_valid", bus.pkt_valid, 0);
        check_val("arst_tx_active", tx_active, 0);
        check_val("arst_count", count, 0);
        check_val("arst_ld_ready", bus.ld_ready, 1);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_count", count, 0);
        check_val("post_rst_idle", tx_active, 0);
        check_val("post_rst_ld_ready", bus.ld_ready, 1);

        // random traffic
        for (int r = 0; r < 30; r++) begin
            int nl, ln;
            nl = $urandom_range(6);
            for (int i = 0; i < nl; i++) load_byte(8'($urandom_range(255)));
            ln = $urandom_range(model_q.size() + 2);
            if (ln > 63) ln = 63;
            send_pkt(ln, $urandom_range(3), 1'($urandom_range(1)), 30, -1, 0,
                     int'($urandom_range(3)) - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port. It buffers payload bytes from a local load interface and, on command, transmits one router packet. Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte. It honours the router's busy back-pressure, then samples the router's err flag and reports per-packet status.

Parameters:
DEPTH, 16, payload buffer depth in bytes, power of two, max 63
ERR_WAIT, 3, cycles after the parity byte during which router err is sampled

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
ld_valid  in  1  payload byte offered to buffer
ld_data  in  8  payload byte
ld_ready  out  1  buffer accepts byte; high only when state==IDLE and count<DEPTH
start  in  1  transmit request; sampled in IDLE only
dest_addr  in  2  destination channel, 0..2
pay_len  in  6  payload length
inj_perr  in  1  invert parity bit0 for this packet; captured with start
router_busy  in  1  router busy; hold the current byte
router_err  in  1  router parity-error flag
pkt_valid  out  1  router packet_valid
pkt_data  out  8  router datain
tx_active  out  1  state != IDLE
count  out  $clog2(DEPTH)+1  bytes currently buffered
done  out  1  one-cycle pulse at end of packet
err_seen  out  1  router_err was observed during the ERR_WAIT window; valid with done, held until next start
cmd_reject  out  1  one-cycle pulse: start refused

Behaviour:
- Reset values: all outputs 0 except ld_ready=1. Buffer is emptied and state=IDLE. Reset mid-packet aborts immediately; pkt_valid drops asynchronously.
- Load: a handshake on ld_valid&ld_ready writes ld_data at the wr pointer. Pointers wrap modulo DEPTH.
- Start in IDLE is rejected when pay_len==0, pay_len>count, or dest_addr==3. A rejected start pulses cmd_reject next cycle and the block stays IDLE.
- An accepted start captures len, addr and inj_perr, seeds parity = header, and goes to HEADER next cycle.
- FSM states: IDLE, HEADER, PAYLOAD, PARITY, ERRCHK.
  - HEADER: pkt_valid=1, pkt_data=header.
  - PAYLOAD: pkt_valid=1, pkt_data=buf[rd]. parity ^= byte on each advance; rd++; remaining--. After the last byte go to PARITY.
  - PARITY: pkt_valid=0, pkt_data=parity^{7'b0,inj_perr}.
  - ERRCHK: pkt_valid=0, pkt_data=0 for ERR_WAIT cycles. err_seen |= router_err. On exit, done pulses and state returns to IDLE.
- Advance rule for HEADER/PAYLOAD/PARITY: leave the byte at a clock edge only if router_busy==0 at that edge. Otherwise the same byte and pkt_valid are re-presented. Consecutive busy cycles are unbounded.
- All outputs are registered. With busy held low, a packet occupies len+2 cycles on pkt_data, with the header one cycle after the start edge.
- start while not IDLE is ignored, with no reject. ld_valid while not IDLE is not accepted.
- count decrements as payload bytes are read. Bytes beyond len remain buffered for the next packet.
- Counters are 6 bits for len and $clog2(DEPTH)+1 bits for count. There is no overflow path because load is blocked at DEPTH.

Decomposition:
- Shared package router_pkg:
  - header field widths and positions (LEN_W=6, ADDR_W=2)
  - ADDR_INVALID=2'b11
  - FSM state enum tx_state_t
  - function make_header(len, addr)
  - function xor8
- One natural sub-module: router_tx_buf, a DEPTH x 8 circular buffer with wr/rd pointers and count. The packet FSM stays in router_pkt_tx.

Test Plan:
1. Load AA,55,CC,33; start addr=1 len=4, busy=0 -> pkt_data 0x11,AA,55,CC,33 with pkt_valid=1, then 0x11 (parity) with pkt_valid=0; done after 3 more cycles; err_seen=0; count 4->0.
2. Same packet, router_busy=1 for 2 cycles while 0x55 is presented -> 0x55 is held 3 cycles with pkt_valid=1; sequence and parity otherwise unchanged; total length 8 cycles.
3. Same packet with inj_perr=1; bench router model asserts router_err 2 cycles after parity -> parity byte is 0x10; err_seen=1 when done pulses.
4. Rejects: start with len=0, with len=5 while count=4, and with addr=3 -> cmd_reject pulses each time; pkt_valid stays 0; count unchanged.
5. Load 16 bytes -> ld_ready=0 once count=16 and a 17th byte is not accepted. Send len=10 to addr 2 (header 0x2A), then len=6 -> second packet carries bytes 11..16 in order across pointer wrap.
6. Assert rst_n=0 mid-PAYLOAD -> pkt_valid=0 immediately; after release count=0, ld_ready=1, state IDLE.
